ps2_key_tracker: RTL and testbench

Parametrised PS/2 set-2 scan-code tracker. It sits between the `ps2_keyboard` receiver FIFO and the board's seven-segment digits, and pops bytes through the receiver's `nextdata_n` handshake. It parses E0 (extended) and F0 (break) prefixes, tracks the currently held key, and optionally filters typematic repeats. It also counts key presses in BCD and drives a configurable row of segment digits.

---
 rtl/ps2_pkg.sv | 46 ++++
 rtl/ps2_ascii_rom.sv | 53 +++++
 rtl/ps2_key_tracker.sv | 129 ++++++++++++
 tb/tb_ps2_key_tracker.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants, FSM state type and digit encoder
// for the PS/2 key tracker.
package ps2_pkg;

   localparam logic [7:0] PS2_EXT = 8'hE0;
   localparam logic [7:0] PS2_BRK = 8'hF0;

   typedef enum logic [1:0] {
      ST_WAIT,
      ST_POP,
      ST_GAP
   } ps2_state_e;

   // Keyboard status/ack bytes that never carry a key.
   function automatic logic is_ctrl(logic [7:0] b);
      return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) ||
             (b == 8'hFA) || (b == 8'hFC) || (b == 8'hFE) ||
             (b == 8'hFF);
   endfunction

   function automatic logic [6:0] hex7(logic [3:0] v);
      logic [6:0] s;
      s = 7'h00;
      case (v)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         4'hF: s = 7'h71;
         default: s = 7'h00;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/ps2_ascii_rom.sv
// Set-2 make code to ASCII lookup: lowercase letters,
// digits, space and enter; 0x00 for anything else.
module ps2_ascii_rom (
   input  logic [7:0] code,
   output logic [7:0] ascii
);

   always_comb begin
      ascii = 8'h00;
      case (code)
         8'h1C: ascii = 8'h61;
         8'h32: ascii = 8'h62;
         8'h21: ascii = 8'h63;
         8'h23: ascii = 8'h64;
         8'h24: ascii = 8'h65;
         8'h2B: ascii = 8'h66;
         8'h34: ascii = 8'h67;
         8'h33: ascii = 8'h68;
         8'h43: ascii = 8'h69;
         8'h3B: ascii = 8'h6A;
         8'h42: ascii = 8'h6B;
         8'h4B: ascii = 8'h6C;
         8'h3A: ascii = 8'h6D;
         8'h31: ascii = 8'h6E;
         8'h44: ascii = 8'h6F;
         8'h4D: ascii = 8'h70;
         8'h15: ascii = 8'h71;
         8'h2D: ascii = 8'h72;
         8'h1B: ascii = 8'h73;
         8'h2C: ascii = 8'h74;
         8'h3C: ascii = 8'h75;
         8'h2A: ascii = 8'h76;
         8'h1D: ascii = 8'h77;
         8'h22: ascii = 8'h78;
         8'h35: ascii = 8'h79;
         8'h1A: ascii = 8'h7A;
         8'h45: ascii = 8'h30;
         8'h16: ascii = 8'h31;
         8'h1E: ascii = 8'h32;
         8'h26: ascii = 8'h33;
         8'h25: ascii = 8'h34;
         8'h2E: ascii = 8'h35;
         8'h36: ascii = 8'h36;
         8'h3D: ascii = 8'h37;
         8'h3E: ascii = 8'h38;
         8'h46: ascii = 8'h39;
         8'h29: ascii = 8'h20;
         8'h5A: ascii = 8'h0D;
         default: ascii = 8'h00;
      endcase
   end

endmodule

// File: rtl/ps2_key_tracker.sv
// Pops scan codes from the PS/2 receiver FIFO, tracks the held
// key, counts presses in BCD and drives the segment digits.
module ps2_key_tracker
   import ps2_pkg::*;
#(
   parameter int CNT_DIGITS       = 2,
   parameter bit TYPEMATIC_FILTER = 1'b1,
   parameter bit SEG_ACTIVE_LOW   = 1'b1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [7:0]                  kb_data,
   input  logic                        kb_ready,
   output logic                        kb_next,
   output logic                        key_valid,
   output logic [7:0]                  key_code,
   output logic                        key_ext,
   output logic [7:0]                  key_ascii,
   output logic                        press_pulse,
   output logic [4*CNT_DIGITS-1:0]     press_cnt,
   output logic [8*(4+CNT_DIGITS)-1:0] seg
);

   ps2_state_e state;
   logic [7:0] byte_q;
   logic       ext_p;
   logic       brk_p;
   logic [7:0] rom_ascii;
   logic       match;
   logic       carry;
   logic [4*CNT_DIGITS-1:0]     cnt_inc;
   logic [8*(4+CNT_DIGITS)-1:0] seg_nx;
   logic [8*(4+CNT_DIGITS)-1:0] seg_q;

   ps2_ascii_rom u_rom (
      .code  (byte_q),
      .ascii (rom_ascii)
   );

   assign match = key_valid && (byte_q == key_code) &&
                  (ext_p == key_ext);

   always_comb begin
      cnt_inc = press_cnt;
      carry   = 1'b1;
      for (int i = 0; i < CNT_DIGITS; i++) begin
         if (carry) begin
            if (press_cnt[4*i +: 4] == 4'd9) begin
               cnt_inc[4*i +: 4] = 4'd0;
            end else begin
               cnt_inc[4*i +: 4] = press_cnt[4*i +: 4] + 4'd1;
               carry = 1'b0;
            end
         end
      end
   end

   always_comb begin
      seg_nx = '0;
      if (key_valid) begin
         seg_nx[6:0]  = hex7(key_code[3:0]);
         seg_nx[14:8] = hex7(key_code[7:4]);
      end
      if (key_valid && (key_ascii != 8'h00)) begin
         seg_nx[22:16] = hex7(key_ascii[3:0]);
         seg_nx[30:24] = hex7(key_ascii[7:4]);
      end
      for (int i = 0; i < CNT_DIGITS; i++)
         seg_nx[8*(4+i) +: 7] = hex7(press_cnt[4*i +: 4]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_WAIT;
         kb_next     <= 1'b1;
         byte_q      <= 8'h00;
         ext_p       <= 1'b0;
         brk_p       <= 1'b0;
         key_valid   <= 1'b0;
         key_code    <= 8'h00;
         key_ext     <= 1'b0;
         key_ascii   <= 8'h00;
         press_pulse <= 1'b0;
         press_cnt   <= '0;
         seg_q       <= '0;
      end else begin
         kb_next     <= 1'b1;
         press_pulse <= 1'b0;
         seg_q       <= seg_nx;
         unique case (state)
            ST_WAIT: begin
               if (kb_ready) begin
                  byte_q  <= kb_data;
                  kb_next <= 1'b0;
                  state   <= ST_POP;
               end
            end
            ST_POP: begin
               state <= ST_GAP;
               if (byte_q == PS2_EXT) begin
                  ext_p <= 1'b1;
               end else if (byte_q == PS2_BRK) begin
                  brk_p <= 1'b1;
               end else if (!is_ctrl(byte_q)) begin
                  ext_p <= 1'b0;
                  if (brk_p) begin
                     brk_p <= 1'b0;
                     if (match)
                        key_valid <= 1'b0;
                  end else if (!(TYPEMATIC_FILTER && match)) begin
                     key_code    <= byte_q;
                     key_ext     <= ext_p;
                     key_ascii   <= ext_p ? 8'h00 : rom_ascii;
                     key_valid   <= 1'b1;
                     press_pulse <= 1'b1;
                     press_cnt   <= cnt_inc;
                  end
               end
            end
            ST_GAP: state <= ST_WAIT;
            default: state <= ST_WAIT;
         endcase
      end
   end

   // Segment patterns are built active-high; polarity fixed here.
   assign seg = SEG_ACTIVE_LOW ? ~seg_q : seg_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Randomized and directed bench for ps2_key_tracker against
// a behavioural key/press model and a receiver FIFO emulation.
module tb_ps2_key_tracker;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  kb_data;
   logic        kb_ready;

   logic        kb_next, key_valid, key_ext, press_pulse;
   logic [7:0]  key_code, key_ascii, press_cnt;
   logic [47:0] seg;

   logic        nf_next, nf_valid, nf_ext, nf_pulse;
   logic [7:0]  nf_code, nf_ascii, nf_cnt;
   logic [47:0] nf_seg;

   ps2_key_tracker dut (
      .clk(clk), .rst(rst), .kb_data(kb_data), .kb_ready(kb_ready),
      .kb_next(kb_next), .key_valid(key_valid), .key_code(key_code),
      .key_ext(key_ext), .key_ascii(key_ascii),
      .press_pulse(press_pulse), .press_cnt(press_cnt), .seg(seg)
   );

   ps2_key_tracker #(.TYPEMATIC_FILTER(1'b0)) dut_nf (
      .clk(clk), .rst(rst), .kb_data(kb_data), .kb_ready(kb_ready),
      .kb_next(nf_next), .key_valid(nf_valid), .key_code(nf_code),
      .key_ext(nf_ext), .key_ascii(nf_ascii),
      .press_pulse(nf_pulse), .press_cnt(nf_cnt), .seg(nf_seg)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic [7:0] fifo[$];
   int pops[$];
   bit chk_out = 0, chk_seg = 0, drop = 0;

   bit m_ext_p, m_brk_p, m_valid, m_kext, m_pulse, m_pulse_nf;
   logic [7:0] m_code, m_ascii;
   int m_cnt, m_cnt_nf;

   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] asc(logic [7:0] c);
      case (c)
         8'h1C: return 8'h61;  8'h32: return 8'h62;  8'h21: return 8'h63;
         8'h23: return 8'h64;  8'h24: return 8'h65;  8'h2B: return 8'h66;
         8'h34: return 8'h67;  8'h33: return 8'h68;  8'h43: return 8'h69;
         8'h3B: return 8'h6A;  8'h42: return 8'h6B;  8'h4B: return 8'h6C;
         8'h3A: return 8'h6D;  8'h31: return 8'h6E;  8'h44: return 8'h6F;
         8'h4D: return 8'h70;  8'h15: return 8'h71;  8'h2D: return 8'h72;
         8'h1B: return 8'h73;  8'h2C: return 8'h74;  8'h3C: return 8'h75;
         8'h2A: return 8'h76;  8'h1D: return 8'h77;  8'h22: return 8'h78;
         8'h35: return 8'h79;  8'h1A: return 8'h7A;  8'h45: return 8'h30;
         8'h16: return 8'h31;  8'h1E: return 8'h32;  8'h26: return 8'h33;
         8'h25: return 8'h34;  8'h2E: return 8'h35;  8'h36: return 8'h36;
         8'h3D: return 8'h37;  8'h3E: return 8'h38;  8'h46: return 8'h39;
         8'h29: return 8'h20;  8'h5A: return 8'h0D;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [6:0] h7(logic [3:0] v);
      logic [6:0] t[16];
      t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
      return t[v];
   endfunction

   function automatic logic [7:0] bcd(int n);
      return {4'(n / 10), 4'(n % 10)};
   endfunction

   function automatic logic [47:0] exp_seg();
      logic [47:0] s;
      s = '0;
      if (m_valid) begin
         s[6:0]  = h7(m_code[3:0]);
         s[14:8] = h7(m_code[7:4]);
      end
      if (m_valid && m_ascii != 8'h00) begin
         s[22:16] = h7(m_ascii[3:0]);
         s[30:24] = h7(m_ascii[7:4]);
      end
      s[38:32] = h7(4'(m_cnt % 10));
      s[46:40] = h7(4'(m_cnt / 10));
      return ~s;
   endfunction

   function automatic void model_reset();
      m_ext_p = 0; m_brk_p = 0; m_valid = 0; m_kext = 0;
      m_code = 0; m_ascii = 0; m_cnt = 0; m_cnt_nf = 0;
      m_pulse = 0; m_pulse_nf = 0;
   endfunction

   function automatic void model(logic [7:0] b);
      bit ignored;
      ignored = (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) ||
                (b == 8'hFA) || (b == 8'hFC) || (b == 8'hFE) || (b == 8'hFF);
      m_pulse = 0;
      m_pulse_nf = 0;
      if (b == 8'hE0) m_ext_p = 1;
      else if (b == 8'hF0) m_brk_p = 1;
      else if (!ignored) begin
         if (m_brk_p) begin
            if (m_valid && b == m_code && m_ext_p == m_kext) m_valid = 0;
         end else begin
            m_pulse_nf = 1;
            m_cnt_nf = (m_cnt_nf + 1) % 100;
            if (!(m_valid && b == m_code && m_ext_p == m_kext)) begin
               m_code = b;
               m_kext = m_ext_p;
               m_ascii = m_ext_p ? 8'h00 : asc(b);
               m_valid = 1;
               m_pulse = 1;
               m_cnt = (m_cnt + 1) % 100;
            end
         end
         m_ext_p = 0;
         m_brk_p = 0;
      end
   endfunction

   // One cycle: check pending results, emulate the receiver FIFO pop.
   task automatic tick();
      logic [7:0] b;
      @(negedge clk);
      cyc++;
      if (chk_out) begin
         chk("key_valid", key_valid, m_valid);
         chk("key_code", key_code, m_code);
         chk("key_ext", key_ext, m_kext);
         chk("key_ascii", key_ascii, m_ascii);
         chk("press_pulse", press_pulse, m_pulse);
         chk("press_cnt", press_cnt, bcd(m_cnt));
         chk("nf_pulse", nf_pulse, m_pulse_nf);
         chk("nf_cnt", nf_cnt, bcd(m_cnt_nf));
         chk_out = 0;
         chk_seg = 1;
      end else if (chk_seg) begin
         chk("seg", seg, exp_seg());
         chk_seg = 0;
      end
      if (!kb_next && fifo.size() != 0) begin
         b = fifo.pop_front();
         pops.push_back(cyc);
         if (!drop) begin
            model(b);
            chk_out = 1;
         end
      end
      kb_ready = (fifo.size() != 0);
      kb_data = (fifo.size() != 0) ? fifo[0] : 8'h00;
   endtask

   task automatic drain();
      int guard = 0;
      while (fifo.size() != 0 && guard < 2000) begin
         tick();
         guard++;
      end
      if (guard >= 2000) chk("drain_timeout", 1, 0);
      repeat (6) tick();
   endtask

   task automatic do_reset();
      rst = 1;
      repeat (2) tick();
      rst = 0;
      model_reset();
      chk_out = 0;
      chk_seg = 0;
   endtask

   task automatic chk_reset_state(string tag);
      chk({tag, "_kb_next"}, kb_next, 1'b1);
      chk({tag, "_valid"}, key_valid, 1'b0);
      chk({tag, "_code"}, key_code, 8'h00);
      chk({tag, "_ext"}, key_ext, 1'b0);
      chk({tag, "_ascii"}, key_ascii, 8'h00);
      chk({tag, "_pulse"}, press_pulse, 1'b0);
      chk({tag, "_cnt"}, press_cnt, 8'h00);
      chk({tag, "_seg"}, seg, 48'hFFFF_FFFF_FFFF);
   endtask

   logic [7:0] pool[16];

   initial begin
      rst = 1;
      kb_ready = 0;
      kb_data = 0;
      model_reset();
      repeat (3) tick();
      chk_reset_state("rst");
      rst = 0;

      // single make
      pops.delete();
      fifo.push_back(8'h1C);
      drain();
      chk("t1_pops", pops.size(), 1);
      chk("t1_code", key_code, 8'h1C);
      chk("t1_ascii", key_ascii, 8'h61);
      chk("t1_cnt", press_cnt, 8'h01);
      chk("t1_seg10", seg[15:0], 16'hF9C6);

      // typematic repeat then release
      do_reset();
      fifo.push_back(8'h1C); fifo.push_back(8'h1C);
      fifo.push_back(8'hF0); fifo.push_back(8'h1C);
      drain();
      chk("t2_cnt", press_cnt, 8'h01);
      chk("t2_nf_cnt", nf_cnt, 8'h02);
      chk("t2_valid", key_valid, 1'b0);

      // extended key, plain break must not release it
      do_reset();
      fifo.push_back(8'hE0); fifo.push_back(8'h75);
      drain();
      chk("t3_ext", key_ext, 1'b1);
      chk("t3_ascii", key_ascii, 8'h00);
      chk("t3_seg32", seg[31:16], 16'hFFFF);
      fifo.push_back(8'hF0); fifo.push_back(8'h75);
      drain();
      chk("t3_hold", key_valid, 1'b1);
      fifo.push_back(8'hE0); fifo.push_back(8'hF0); fifo.push_back(8'h75);
      drain();
      chk("t3_rel", key_valid, 1'b0);

      // BCD wrap
      do_reset();
      for (int i = 0; i < 100; i++) fifo.push_back(i % 2 ? 8'h1E : 8'h16);
      drain();
      chk("t4_wrap", press_cnt, 8'h00);
      fifo.push_back(8'h16);
      drain();
      chk("t4_101", press_cnt, 8'h01);

      // back-to-back pops
      pops.delete();
      fifo.push_back(8'h16); fifo.push_back(8'h1E);
      fifo.push_back(8'h26); fifo.push_back(8'h25);
      drain();
      chk("t5_pops", pops.size(), 4);
      for (int i = 1; i < pops.size(); i++)
         chk("t5_gap", pops[i] - pops[i-1], 3);

      // random traffic
      pool = '{8'hE0, 8'hF0, 8'hF0, 8'h1C, 8'h1C, 8'h75, 8'h29, 8'h5A,
               8'h32, 8'h0E, 8'hAA, 8'hFA, 8'h00, 8'h1C, 8'h75, 8'hE0};
      for (int r = 0; r < 40; r++) begin
         int n = $urandom_range(1, 8);
         for (int k = 0; k < n; k++) fifo.push_back(pool[$urandom_range(0, 15)]);
         repeat ($urandom_range(0, 3)) tick();
         drain();
      end

      // reset while a byte is in POP
      fifo.push_back(8'h1C);
      drain();
      drop = 1;
      pops.delete();
      fifo.push_back(8'h32);
      begin
         int guard = 0;
         while (pops.size() == 0 && guard < 50) begin
            tick();
            guard++;
         end
         if (guard >= 50) chk("t6_timeout", 1, 0);
      end
      rst = 1;
      tick();
      chk_reset_state("t6");
      rst = 0;
      drop = 0;
      model_reset();
      repeat (3) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
